// File: rtl/sound_i2s_tx.sv
// Audio output stage: box-filters the sound unit mix words over one frame,
// removes the DC offset and serializes signed stereo samples in Philips I2S format.
module sound_i2s_tx #(
  parameter int unsigned DIV_LOG2 = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] left,
  input  logic [15:0] right,
  output logic        i2s_bclk,
  output logic        i2s_lrck,
  output logic        i2s_sdata,
  output logic        sample_strobe,
  output logic [15:0] sample_l,
  output logic [15:0] sample_r
);

  localparam int unsigned N  = 6 + DIV_LOG2;
  localparam int unsigned AW = 16 + N;
  localparam logic [N-1:0] CNT_LAST = '1;
  localparam logic [15:0]  DC_MID   = 16'h4000;

  logic [N-1:0]  cnt;
  logic [AW-1:0] acc_l;
  logic [AW-1:0] acc_r;
  logic [4:0]    slot;
  logic          last;
  logic [15:0]   avg_l;
  logic [15:0]   avg_r;

  // Slot decode and end-of-frame average (includes the current input word)
  always_comb begin
    slot  = cnt[N-1:DIV_LOG2+1];
    last  = (cnt == CNT_LAST);
    avg_l = 16'((acc_l + AW'(left))  >> N);
    avg_r = 16'((acc_r + AW'(right)) >> N);
  end

  // Frame counter, accumulators and sample latch
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt           <= '0;
      acc_l         <= '0;
      acc_r         <= '0;
      sample_l      <= '0;
      sample_r      <= '0;
      sample_strobe <= 1'b0;
    end else begin
      cnt <= cnt + N'(1);
      if (last) begin
        acc_l         <= '0;
        acc_r         <= '0;
        sample_l      <= en ? (avg_l - DC_MID) : 16'h0000;
        sample_r      <= en ? (avg_r - DC_MID) : 16'h0000;
        sample_strobe <= 1'b1;
      end else begin
        acc_l         <= acc_l + AW'(left);
        acc_r         <= acc_r + AW'(right);
        sample_strobe <= 1'b0;
      end
    end
  end

  // Serializer; slot 31 reads the pre-latch sample_r, so the right LSB survives the wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      i2s_bclk  <= 1'b0;
      i2s_lrck  <= 1'b0;
      i2s_sdata <= 1'b0;
    end else begin
      i2s_bclk  <= cnt[DIV_LOG2];
      i2s_lrck  <= (slot >= 5'd15) && (slot <= 5'd30);
      i2s_sdata <= slot[4] ? sample_r[~slot[3:0]] : sample_l[~slot[3:0]];
    end
  end

endmodule

// File: tb/tb_sound_i2s_tx.sv
// Scoreboard bench for sound_i2s_tx: directed frames push expected samples,
// a monitor checks latched samples, the deserialized I2S words and clock timing.
module tb_sound_i2s_tx;

  localparam int F = 128;

  typedef struct packed {
    logic [15:0] l;
    logic [15:0] r;
  } pair_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [15:0] left = '0;
  logic [15:0] right = '0;
  logic        i2s_bclk, i2s_lrck, i2s_sdata, sample_strobe;
  logic [15:0] sample_l, sample_r;

  int n_vec = 0;
  int n_err = 0;

  pair_t exp_q[$];
  pair_t ser_q[$];

  sound_i2s_tx #(.DIV_LOG2(1)) dut (
    .clk(clk), .rst(rst), .en(en), .left(left), .right(right),
    .i2s_bclk(i2s_bclk), .i2s_lrck(i2s_lrck), .i2s_sdata(i2s_sdata),
    .sample_strobe(sample_strobe), .sample_l(sample_l), .sample_r(sample_r)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One frame of input words; even/odd cycles take a/b, en switches at mid-frame.
  task automatic frame(input logic [15:0] la, input logic [15:0] lb,
                       input logic [15:0] ra, input logic [15:0] rb,
                       input logic en_a, input logic en_b,
                       input logic [15:0] xl, input logic [15:0] xr,
                       input int abort_at);
    pair_t p;
    p.l = xl;
    p.r = xr;
    if (abort_at < 0) exp_q.push_back(p);
    for (int i = 0; i < F; i++) begin
      if (i == abort_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      left  = i[0] ? lb : la;
      right = i[0] ? rb : ra;
      en    = (i < F / 2) ? en_a : en_b;
      @(negedge clk);
    end
  endtask

  // Monitor: samples 1 time unit after each active edge
  initial begin
    int since;
    int bc;
    logic pb, pl, plv;
    logic [31:0] sh;
    pair_t p;
    since = 0; bc = 0; pb = 1'b0; pl = 1'b0; plv = 1'b0; sh = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        chk("reset_outputs",
            {26'd0, i2s_bclk, i2s_lrck, i2s_sdata, sample_strobe, 2'd0} | 32'({sample_l, sample_r} != 32'd0),
            32'd0);
        since = 0; bc = 0; pb = 1'b0; pl = 1'b0; plv = 1'b0;
        ser_q.delete();
        ser_q.push_back('0);
      end else begin
        since++;
        if (sample_strobe) begin
          chk("strobe_phase", 32'(since % F), 32'd0);
          if (exp_q.size() == 0) begin
            chk("strobe_unexpected", 32'd1, 32'd0);
          end else begin
            p = exp_q.pop_front();
            chk("sample_l", 32'(sample_l), 32'(p.l));
            chk("sample_r", 32'(sample_r), 32'(p.r));
            ser_q.push_back(p);
          end
        end
        if (!pb && i2s_bclk) begin
          chk("bclk_rise_phase", 32'(since % 4), 32'd3);
          sh = {sh[30:0], i2s_sdata};
          if (pl && !i2s_lrck) begin
            if (ser_q.size() == 0) chk("serial_r_missing", 32'd1, 32'd0);
            else begin
              p = ser_q.pop_front();
              chk("serial_right", 32'(sh[15:0]), 32'(p.r));
            end
            bc = 0;
          end else begin
            bc++;
            if (bc == 16) begin
              if (ser_q.size() == 0) chk("serial_l_missing", 32'd1, 32'd0);
              else chk("serial_left", 32'(sh[15:0]), 32'(ser_q[0].l));
            end
          end
          pl = i2s_lrck;
        end
        if (pb && !i2s_bclk) chk("bclk_fall_phase", 32'(since % 4), 32'd1);
        if (plv && !i2s_lrck) chk("lrck_fall_phase", 32'(since % F), 32'd125);
        if (!plv && i2s_lrck) chk("lrck_rise_phase", 32'(since % F), 32'd61);
        pb  = i2s_bclk;
        plv = i2s_lrck;
      end
    end
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    // la      lb        ra        rb        en_a  en_b  exp_l     exp_r     abort
    frame(16'h4000, 16'h4000, 16'h4000, 16'h4000, 1'b1, 1'b1, 16'h0000, 16'h0000, -1);
    frame(16'h4000, 16'h4000, 16'h4000, 16'h4000, 1'b1, 1'b1, 16'h0000, 16'h0000, -1);
    frame(16'h7FFF, 16'h7FFF, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h3FFF, 16'hC000, -1);
    frame(16'h0000, 16'h7FFE, 16'h4000, 16'h4000, 1'b1, 1'b1, 16'hFFFF, 16'h0000, -1);
    frame(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b1, 1'b1, 16'h3FFF, 16'h3FFF, -1);
    frame(16'h7FFF, 16'h7FFF, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h0000, -1);
    frame(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b0, 1'b0, 16'h0000, 16'h0000, -1);
    frame(16'h1234, 16'h1234, 16'h5000, 16'h5000, 1'b1, 1'b1, 16'hD234, 16'h1000, -1);
    frame(16'h2000, 16'h2000, 16'h6000, 16'h6000, 1'b1, 1'b1, 16'h0000, 16'h0000, 82);
    frame(16'h6000, 16'h6000, 16'h2000, 16'h2000, 1'b1, 1'b1, 16'h2000, 16'hE000, -1);
    frame(16'h4000, 16'h4000, 16'h4000, 16'h4000, 1'b1, 1'b1, 16'h0000, 16'h0000, -1);
    frame(16'h4000, 16'h4000, 16'h4000, 16'h4000, 1'b1, 1'b1, 16'h0000, 16'h0000, -1);
    repeat (4) @(negedge clk);
    chk("pending_samples", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
